// File: rtl/stream_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_router_pkg
// Brief    : Shared helpers for the stream router crossbar: OPEN select code,
//            IN_W -> OUT_W sample extension and frame length clamping.
// Revision : 1.0 - initial release
// ============================================================================
package stream_router_pkg;

    // Widest sample the extension helper can carry
    localparam int c_max_w = 128;

    // The select code one past the last real source means "not connected"
    function automatic int sel_open(input int n_src);
        return n_src;
    endfunction

    // Sign- or zero-extend the low in_w bits of d across the full word
    function automatic logic [c_max_w-1:0] ext_sample(
        input logic [c_max_w-1:0] d,
        input int                 in_w,
        input logic               sgn
    );
        logic [c_max_w-1:0] r;
        logic               fill;
        r    = '0;
        fill = sgn & d[7'(in_w - 1)];
        for (int i = 0; i < c_max_w; i++) begin
            r[i] = (i < in_w) ? d[i] : fill;
        end
        return r;
    endfunction

    // A frame of 0 samples makes no sense; treat it as 1 (every sample last)
    function automatic logic [31:0] frame_len_clamp(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_router_xbar_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_router_xbar_if
// Brief    : Source and sink stream bundle of the router crossbar. The slave
//            modport is the router; the master modport is its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_router_xbar_if #(
    parameter int N_SRC = 6,
    parameter int N_SNK = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 64,
    parameter int SEL_W = $clog2(N_SRC + 1)
);
    logic [N_SRC*IN_W-1:0]  src_data;
    logic [N_SRC-1:0]       src_valid;
    logic [N_SNK*OUT_W-1:0] snk_data;
    logic [N_SNK-1:0]       snk_valid;
    logic [N_SNK-1:0]       snk_last;
    logic [N_SNK*SEL_W-1:0] snk_sel;
    logic [N_SNK-1:0]       snk_pending;

    modport master (
        output src_data, src_valid,
        input  snk_data, snk_valid, snk_last, snk_sel, snk_pending
    );

    modport slave (
        input  src_data, src_valid,
        output snk_data, snk_valid, snk_last, snk_sel, snk_pending
    );
endinterface
`default_nettype wire

// File: rtl/stream_router_sink.sv
`default_nettype none
// ============================================================================
// Module   : stream_router_sink
// Brief    : One sink of the router: active/pending select, frame counter,
//            optional decimator (STREAM_ROUTER_DECIM_EN) and output register.
// Revision : 1.0 - initial release
// ============================================================================
module stream_router_sink
    import stream_router_pkg::*;
#(
    parameter int N_SRC      = 6,
    parameter int IN_W       = 32,
    parameter int OUT_W      = 64,
    parameter int SIGNED_EXT = 1,
    parameter int SEL_W      = $clog2(N_SRC + 1)
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  i_enable,
    input  wire logic [N_SRC*IN_W-1:0] i_src_data,
    input  wire logic [N_SRC-1:0]      i_src_valid,
    input  wire logic [31:0]           i_frame_len,
    input  wire logic                  i_cfg_we,
    input  wire logic [SEL_W-1:0]      i_cfg_src,
`ifdef STREAM_ROUTER_DECIM_EN
    input  wire logic [15:0]           i_cfg_decim,
`endif
    output logic [OUT_W-1:0]           o_snk_data,
    output logic                       o_snk_valid,
    output logic                       o_snk_last,
    output logic [SEL_W-1:0]           o_snk_sel,
    output logic                       o_snk_pending
);

    localparam logic [SEL_W-1:0] c_open = SEL_W'(sel_open(N_SRC));

    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_pend_sel;
    logic             r_pend;
    logic [31:0]      r_cnt;
    logic [OUT_W-1:0] r_data;
    logic             r_valid;
    logic             r_last;

    logic [IN_W-1:0]  w_src_data;
    logic             w_src_valid;
    logic             w_hit;
    logic             w_take;
    logic             w_wrap;
    logic             w_apply;
    logic [31:0]      w_len;

    // Source mux; OPEN matches no source so it never yields a valid sample
    always_comb begin
        w_src_data  = '0;
        w_src_valid = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_src_data  = i_src_data[i*IN_W +: IN_W];
                w_src_valid = i_src_valid[i];
            end
        end
    end

`ifdef STREAM_ROUTER_DECIM_EN
    logic [15:0] r_decim;
    logic [15:0] r_pend_decim;
    logic [15:0] r_phase;
    logic [15:0] w_dec;

    assign w_dec = (r_decim == 16'd0) ? 16'd1 : r_decim;
    assign w_hit = (r_phase >= w_dec - 16'd1);

    // Decimation factor follows the select through pending/apply; phase restarts on apply
    always_ff @(posedge clk) begin
        if (reset) begin
            r_decim      <= 16'd0;
            r_pend_decim <= 16'd0;
            r_phase      <= 16'd0;
        end else begin
            if (w_apply) begin
                r_decim <= r_pend_decim;
                r_phase <= 16'd0;
            end else if (i_enable && w_src_valid) begin
                r_phase <= w_hit ? 16'd0 : r_phase + 16'd1;
            end
            if (i_cfg_we) begin
                r_pend_decim <= i_cfg_decim;
            end
        end
    end
`else
    assign w_hit = 1'b1;
`endif

    assign w_len   = frame_len_clamp(i_frame_len);
    assign w_take  = i_enable && w_src_valid && w_hit;
    // >= so that shrinking frame_len mid-frame closes the frame on the next sample
    assign w_wrap  = w_take && (r_cnt >= w_len - 32'd1);
    assign w_apply = r_pend && (!i_enable || w_wrap || ((r_cnt == 32'd0) && !w_take));

    // Select/pending registers; a write in the same cycle as an apply re-arms pending
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel      <= c_open;
            r_pend_sel <= c_open;
            r_pend     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_sel  <= r_pend_sel;
                r_pend <= 1'b0;
            end
            if (i_cfg_we) begin
                r_pend_sel <= i_cfg_src;
                r_pend     <= 1'b1;
            end
        end
    end

    // Frame counter over forwarded samples; cleared while disabled and on apply
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 32'd0;
        end else if (!i_enable || w_apply) begin
            r_cnt <= 32'd0;
        end else if (w_take) begin
            r_cnt <= w_wrap ? 32'd0 : r_cnt + 32'd1;
        end
    end

    // Output register: data holds between valid samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= w_take;
            r_last  <= w_wrap;
            if (w_take) begin
                r_data <= OUT_W'(ext_sample(c_max_w'(w_src_data), IN_W, SIGNED_EXT != 0));
            end
        end
    end

    assign o_snk_data    = r_data;
    assign o_snk_valid   = r_valid;
    assign o_snk_last    = r_last;
    assign o_snk_sel     = r_sel;
    assign o_snk_pending = r_pend;

endmodule
`default_nettype wire

// File: rtl/stream_router_xbar.sv
`default_nettype none
// ============================================================================
// Module   : stream_router_xbar
// Brief    : N_SRC x N_SNK streaming crossbar with frame-aligned select
//            changes. Holds config decode and cfg_err; sinks do the rest.
//            Optional per-sink decimation with STREAM_ROUTER_DECIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stream_router_xbar
    import stream_router_pkg::*;
#(
    parameter int N_SRC      = 6,
    parameter int N_SNK      = 4,
    parameter int IN_W       = 32,
    parameter int OUT_W      = 64,
    parameter int SIGNED_EXT = 1,
    parameter int SEL_W      = $clog2(N_SRC + 1),
    parameter int CFG_SNK_W  = (N_SNK > 1) ? $clog2(N_SNK) : 1
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 enable,
    input  wire logic [31:0]          frame_len,
    input  wire logic                 cfg_wr,
    input  wire logic [CFG_SNK_W-1:0] cfg_snk,
    input  wire logic [SEL_W-1:0]     cfg_src,
`ifdef STREAM_ROUTER_DECIM_EN
    input  wire logic [15:0]          cfg_decim,
`endif
    output logic                      cfg_err,
    stream_router_xbar_if.slave       bus
);

    localparam logic [SEL_W-1:0]   c_open  = SEL_W'(sel_open(N_SRC));
    localparam logic [CFG_SNK_W:0] c_n_snk = (CFG_SNK_W + 1)'(N_SNK);

    logic             r_cfg_err;
    logic             w_bad;
    logic [N_SNK-1:0] w_we;
    logic [OUT_W-1:0] w_snk_data [N_SNK];
    logic [SEL_W-1:0] w_snk_sel  [N_SNK];
    logic [N_SNK-1:0] w_snk_valid;
    logic [N_SNK-1:0] w_snk_last;
    logic [N_SNK-1:0] w_snk_pending;

    assign w_bad = cfg_wr && (({1'b0, cfg_snk} >= c_n_snk) || (cfg_src > c_open));

    // Route an accepted write to exactly one sink
    always_comb begin
        w_we = '0;
        for (int k = 0; k < N_SNK; k++) begin
            w_we[k] = cfg_wr && !w_bad && (cfg_snk == CFG_SNK_W'(k));
        end
    end

    // Rejected writes pulse cfg_err for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_bad;
        end
    end

    assign cfg_err = r_cfg_err;

    generate
        for (genvar k = 0; k < N_SNK; k++) begin : g_sink
            stream_router_sink #(
                .N_SRC      (N_SRC),
                .IN_W       (IN_W),
                .OUT_W      (OUT_W),
                .SIGNED_EXT (SIGNED_EXT),
                .SEL_W      (SEL_W)
            ) u_sink (
                .clk           (clk),
                .reset         (reset),
                .i_enable      (enable),
                .i_src_data    (bus.src_data),
                .i_src_valid   (bus.src_valid),
                .i_frame_len   (frame_len),
                .i_cfg_we      (w_we[k]),
                .i_cfg_src     (cfg_src),
`ifdef STREAM_ROUTER_DECIM_EN
                .i_cfg_decim   (cfg_decim),
`endif
                .o_snk_data    (w_snk_data[k]),
                .o_snk_valid   (w_snk_valid[k]),
                .o_snk_last    (w_snk_last[k]),
                .o_snk_sel     (w_snk_sel[k]),
                .o_snk_pending (w_snk_pending[k])
            );
        end
    endgenerate

    // Flatten per-sink outputs onto the bus
    always_comb begin
        bus.snk_data    = '0;
        bus.snk_sel     = '0;
        bus.snk_valid   = w_snk_valid;
        bus.snk_last    = w_snk_last;
        bus.snk_pending = w_snk_pending;
        for (int k = 0; k < N_SNK; k++) begin
            bus.snk_data[k*OUT_W +: OUT_W] = w_snk_data[k];
            bus.snk_sel[k*SEL_W +: SEL_W]  = w_snk_sel[k];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_router_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_router_xbar
// Brief    : Directed testbench for stream_router_xbar (table vectors plus
//            hand sequences; decimation section with STREAM_ROUTER_DECIM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stream_router_xbar;

    localparam int N_SRC = 6;
    localparam int N_SNK = 4;
    localparam int IN_W  = 32;
    localparam int OUT_W = 64;
    localparam int SEL_W = 3;

    localparam logic [63:0] c_s1 = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] c_s3 = 64'h0000_0000_0000_1234;

    typedef struct {
        logic        en;
        logic [31:0] flen;
        logic        wr;
        logic [1:0]  snk;
        logic [2:0]  src;
        logic [5:0]  sv;
        logic [2:0]  e_sel;
        logic        e_pend;
        logic        e_v;
        logic        e_l;
        logic [63:0] e_d;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] frame_len;
    logic        cfg_wr;
    logic [1:0]  cfg_snk;
    logic [2:0]  cfg_src;
    logic        cfg_err;
`ifdef STREAM_ROUTER_DECIM_EN
    logic [15:0] cfg_decim;
`endif

    int nchecks = 0;
    int nfail   = 0;
    vec_t vecs[$];

    stream_router_xbar_if #(
        .N_SRC(N_SRC), .N_SNK(N_SNK), .IN_W(IN_W), .OUT_W(OUT_W), .SEL_W(SEL_W)
    ) bus ();

    stream_router_xbar #(
        .N_SRC(N_SRC), .N_SNK(N_SNK), .IN_W(IN_W), .OUT_W(OUT_W),
        .SIGNED_EXT(1), .SEL_W(SEL_W), .CFG_SNK_W(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .frame_len (frame_len),
        .cfg_wr    (cfg_wr),
        .cfg_snk   (cfg_snk),
        .cfg_src   (cfg_src),
`ifdef STREAM_ROUTER_DECIM_EN
        .cfg_decim (cfg_decim),
`endif
        .cfg_err   (cfg_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [31:0] v);
        bus.src_data[i*IN_W +: IN_W] = v;
    endtask

    function automatic vec_t mk(input logic en, input logic [31:0] flen, input logic wr,
                                input logic [1:0] snk, input logic [2:0] src, input logic [5:0] sv,
                                input logic [2:0] e_sel, input logic e_pend, input logic e_v,
                                input logic e_l, input logic [63:0] e_d, input logic e_err);
        vec_t v;
        v.en = en; v.flen = flen; v.wr = wr; v.snk = snk; v.src = src; v.sv = sv;
        v.e_sel = e_sel; v.e_pend = e_pend; v.e_v = e_v; v.e_l = e_l; v.e_d = e_d; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        logic        exp_v;
        logic [31:0] s4;

        // ------------------------------------------------------------------
        // Vector table for sink 0: select, frame boundary apply, bad write,
        // enable drop with pending write
        // ------------------------------------------------------------------
        vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd6, 0, 0, 0, 64'd0, 0)); // v0 idle
        vecs.push_back(mk(1, 8, 1, 0, 1, 6'b001010, 3'd6, 1, 0, 0, 64'd0, 0)); // v1 write src1
        vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd1, 0, 0, 0, 64'd0, 0)); // v2 applied
        vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd1, 0, 1, 0, c_s1,  0)); // v3 sample 1
        vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd1, 0, 1, 0, c_s1,  0)); // v4 sample 2
        vecs.push_back(mk(1, 8, 1, 0, 3, 6'b001010, 3'd1, 1, 1, 0, c_s1,  0)); // v5 sample 3 + write src3
        for (int i = 0; i < 4; i++)                                          // v6..v9 samples 4..7
            vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd1, 1, 1, 0, c_s1, 0));
        vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd3, 0, 1, 1, c_s1,  0)); // v10 sample 8 last, apply
        vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd3, 0, 1, 0, c_s3,  0)); // v11 src3 data
        vecs.push_back(mk(1, 8, 1, 0, 7, 6'b001010, 3'd3, 0, 1, 0, c_s3,  1)); // v12 bad src 7
        vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd3, 0, 1, 0, c_s3,  0)); // v13 err one cycle
        vecs.push_back(mk(1, 8, 1, 0, 1, 6'b001010, 3'd3, 1, 1, 0, c_s3,  0)); // v14 pending src1
        vecs.push_back(mk(0, 8, 0, 0, 0, 6'b001010, 3'd1, 0, 0, 0, c_s3,  0)); // v15 enable low applies
        for (int i = 0; i < 7; i++)                                          // v16..v22 samples 1..7
            vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd1, 0, 1, 0, c_s1, 0));
        vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd1, 0, 1, 1, c_s1,  0)); // v23 sample 8 last
        vecs.push_back(mk(1, 8, 0, 0, 0, 6'b001010, 3'd1, 0, 1, 0, c_s1,  0)); // v24 new frame

        // ------------------------------------------------------------------
        // Reset
        // ------------------------------------------------------------------
        reset = 1'b1; enable = 1'b0; frame_len = 32'd8;
        cfg_wr = 1'b0; cfg_snk = 2'd0; cfg_src = 3'd0;
`ifdef STREAM_ROUTER_DECIM_EN
        cfg_decim = 16'd0;
`endif
        bus.src_valid = '0;
        bus.src_data  = '0;
        set_src(0, 32'h0000_0011);
        set_src(1, 32'hFFFF_FFFE);
        set_src(2, 32'h0000_0022);
        set_src(3, 32'h0000_1234);
        set_src(4, 32'h8000_0005);
        set_src(5, 32'h7FFF_FFFF);
        tick();
        tick();
        chk("rst sel",   64'(bus.snk_sel),     64'({4{3'd6}}));
        chk("rst valid", 64'(bus.snk_valid),   64'd0);
        chk("rst last",  64'(bus.snk_last),    64'd0);
        chk("rst pend",  64'(bus.snk_pending), 64'd0);
        chk("rst data0", bus.snk_data[63:0],   64'd0);
        chk("rst data3", bus.snk_data[255:192], 64'd0);
        chk("rst err",   64'(cfg_err),         64'd0);
        reset = 1'b0;

        // ------------------------------------------------------------------
        // Apply the table
        // ------------------------------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            enable        = vecs[i].en;
            frame_len     = vecs[i].flen;
            cfg_wr        = vecs[i].wr;
            cfg_snk       = vecs[i].snk;
            cfg_src       = vecs[i].src;
            bus.src_valid = vecs[i].sv;
            tick();
            chk($sformatf("v%0d sel0", i),  64'(bus.snk_sel[2:0]),     64'(vecs[i].e_sel));
            chk($sformatf("v%0d pend0", i), 64'(bus.snk_pending[0]),   64'(vecs[i].e_pend));
            chk($sformatf("v%0d valid0", i), 64'(bus.snk_valid[0]),    64'(vecs[i].e_v));
            chk($sformatf("v%0d last0", i), 64'(bus.snk_last[0]),      64'(vecs[i].e_l));
            chk($sformatf("v%0d data0", i), bus.snk_data[63:0],        vecs[i].e_d);
            chk($sformatf("v%0d err", i),   64'(cfg_err),              64'(vecs[i].e_err));
        end
        cfg_wr = 1'b0;

        // ------------------------------------------------------------------
        // frame_len = 0: every sample last; sinks 0 and 2 share source 4
        // ------------------------------------------------------------------
        frame_len = 32'd0; enable = 1'b1; bus.src_valid = 6'b111111;
        cfg_wr = 1'b1; cfg_snk = 2'd0; cfg_src = 3'd4;
        tick();
        cfg_snk = 2'd2;
        tick();
        cfg_wr = 1'b0; enable = 1'b0;
        tick();
        chk("fl0 sel0", 64'(bus.snk_sel[2:0]), 64'd4);
        chk("fl0 sel2", 64'(bus.snk_sel[8:6]), 64'd4);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_v = ((i % 3) != 1);
            s4    = 32'h8000_0000 + 32'(i * 3);
            bus.src_valid = {1'b0, exp_v, 4'b0000};
            set_src(4, s4);
            tick();
            chk($sformatf("fl0 c%0d valid0", i), 64'(bus.snk_valid[0]), 64'(exp_v));
            chk($sformatf("fl0 c%0d valid2", i), 64'(bus.snk_valid[2]), 64'(exp_v));
            chk($sformatf("fl0 c%0d last0", i),  64'(bus.snk_last[0]),  64'(exp_v));
            chk($sformatf("fl0 c%0d last2", i),  64'(bus.snk_last[2]),  64'(exp_v));
            if (exp_v) begin
                chk($sformatf("fl0 c%0d data0", i), bus.snk_data[63:0],    {32'hFFFF_FFFF, s4});
                chk($sformatf("fl0 c%0d data2", i), bus.snk_data[191:128], {32'hFFFF_FFFF, s4});
            end
        end

        // ------------------------------------------------------------------
        // Reset mid-frame with a pending write
        // ------------------------------------------------------------------
        frame_len = 32'd8; bus.src_valid = 6'b010000;
        cfg_wr = 1'b1; cfg_snk = 2'd0; cfg_src = 3'd2;
        tick();
        cfg_wr = 1'b0; reset = 1'b1;
        tick();
        chk("mrst sel",   64'(bus.snk_sel),     64'({4{3'd6}}));
        chk("mrst valid", 64'(bus.snk_valid),   64'd0);
        chk("mrst pend",  64'(bus.snk_pending), 64'd0);
        chk("mrst data0", bus.snk_data[63:0],   64'd0);
        chk("mrst data2", bus.snk_data[191:128], 64'd0);
        reset = 1'b0;

`ifdef STREAM_ROUTER_DECIM_EN
        // ------------------------------------------------------------------
        // Decimation D=4, frame_len=2 on sink 1 from source 0
        // ------------------------------------------------------------------
        frame_len = 32'd2; enable = 1'b1; bus.src_valid = '0;
        cfg_wr = 1'b1; cfg_snk = 2'd1; cfg_src = 3'd0; cfg_decim = 16'd4;
        tick();
        cfg_wr = 1'b0; cfg_decim = 16'd0;
        tick();
        chk("dec sel1", 64'(bus.snk_sel[5:3]), 64'd0);
        for (int n = 1; n <= 16; n++) begin
            bus.src_valid = 6'b000001;
            set_src(0, 32'(n));
            tick();
            exp_v = ((n % 4) == 0);
            chk($sformatf("dec n%0d valid1", n), 64'(bus.snk_valid[1]), 64'(exp_v));
            if (exp_v) begin
                chk($sformatf("dec n%0d data1", n), bus.snk_data[127:64], 64'(n));
                chk($sformatf("dec n%0d last1", n), 64'(bus.snk_last[1]), 64'((n % 8) == 0));
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
`default_nettype wire
